io_bridge: RTL and testbench

Sequential bridge between the single-cycle datapath and the memory-mapped peripherals in the 0xFFFFFC00–0xFFFFFFFF window. It consumes the control unit's IORead/IOWrite/MemRead decode plus the low ALU address bits and drives a request/acknowledge peripheral bus. It stalls the CPU until the peripheral acknowledges, then returns write-back data. Memory reads bypass the bridge and are selected through unchanged.

---
 rtl/io_pkg.sv | 23 ++
 rtl/io_addr_decode.sv | 19 +
 rtl/io_bridge.sv | 123 ++++++++++++
 tb/tb_io_bridge.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the IO bridge: FSM states, peripheral word
// addresses, the abort read value and the one-hot chip-select bit positions.
package io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Word addresses are addr[9:2] of the 0xFFFFFC00 window.
  localparam logic [7:0] LED_WA = 8'h18;
  localparam logic [7:0] SW_WA  = 8'h1C;
  localparam logic [7:0] SEG_WA = 8'h20;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  localparam int CS_LED = 0;
  localparam int CS_SW  = 1;
  localparam int CS_SEG = 2;

endpackage

// File: rtl/io_addr_decode.sv
// Combinational peripheral decode: word address -> one-hot chip select and
// a mapped flag (no select bit set means the access hits nothing).
module io_addr_decode
  import io_pkg::*;
(
  input  logic [7:0] word_addr_i,
  output logic [2:0] cs_o,
  output logic       mapped_o
);

  always_comb begin
    cs_o         = '0;
    cs_o[CS_LED] = (word_addr_i == LED_WA);
    cs_o[CS_SW]  = (word_addr_i == SW_WA);
    cs_o[CS_SEG] = (word_addr_i == SEG_WA);
    mapped_o     = |cs_o;
  end

endmodule

// File: rtl/io_bridge.sv
// Request/acknowledge bridge from the single-cycle datapath to the IO window.
// Define IO_TIMEOUT_EN to abort a request that sees no ack within TIMEOUT cycles.
module io_bridge
  import io_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 10
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              io_read,
  input  logic              io_write,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              io_req,
  output logic              io_we,
  output logic [2:0]        io_cs,
  output logic [1:0]        io_addr,
  output logic [31:0]       io_wdata,
  input  logic              io_ack,
  input  logic [31:0]       io_rdata,
  output logic              io_err
);

  state_e      state_q;
  logic        io_req_q, io_we_q;
  logic [2:0]  io_cs_q;
  logic [1:0]  io_addr_q;
  logic [31:0] io_wdata_q, rdata_q;
  logic [2:0]  cs_d;
  logic        mapped_d;
  logic        io_acc;

  assign io_acc = io_read | io_write;

  io_addr_decode u_dec (
    .word_addr_i (addr[9:2]),
    .cs_o        (cs_d),
    .mapped_o    (mapped_d)
  );

`ifdef IO_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       io_err_q;
  assign io_err = io_err_q;
`else
  assign io_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_cs_q    <= '0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
      rdata_q    <= '0;
`ifdef IO_TIMEOUT_EN
      cnt_q      <= '0;
      io_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io_acc) begin
            if (mapped_d) begin
              io_cs_q    <= cs_d;
              io_we_q    <= io_write;
              io_addr_q  <= addr[1:0];
              io_wdata_q <= wdata;
              io_req_q   <= 1'b1;
`ifdef IO_TIMEOUT_EN
              cnt_q      <= '0;
`endif
              state_q    <= ST_REQ;
            end else begin
              rdata_q <= '0;
              state_q <= ST_DONE;
            end
          end
        end
        ST_REQ: begin
          // Ack is checked first so it beats a timeout landing on the same cycle.
          if (io_ack) begin
            if (!io_we_q) rdata_q <= io_rdata;
            io_req_q <= 1'b0;
            state_q  <= ST_DONE;
          end
`ifdef IO_TIMEOUT_EN
          else if (cnt_q == 8'(TIMEOUT - 1)) begin
            io_req_q <= 1'b0;
            rdata_q  <= ERR_DATA;
            io_err_q <= 1'b1;
            state_q  <= ST_ERR;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        // The instruction retires here; its still-high strobes are not re-decoded.
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall    = ((state_q == ST_IDLE) && io_acc) || (state_q == ST_REQ);
  assign rdata    = io_read ? rdata_q : mem_rdata;
  assign io_req   = io_req_q;
  assign io_we    = io_we_q;
  assign io_cs    = io_cs_q;
  assign io_addr  = io_addr_q;
  assign io_wdata = io_wdata_q;

  // mem_read needs no gating: the write-back mux keys off io_read alone.
  logic unused;
  assign unused = ^{mem_read, (TIMEOUT != 0)};

endmodule

// File: tb/tb_io_bridge.sv
// Randomized self-checking bench for io_bridge against a transaction-level model.
module tb_io_bridge;
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        rst_n, io_read, io_write, mem_read, io_ack;
  logic [9:0]  addr;
  logic [31:0] wdata, mem_rdata, io_rdata, rdata, io_wdata;
  logic        stall, io_req, io_we, io_err;
  logic [2:0]  io_cs;
  logic [1:0]  io_addr;

  always #5 clock = ~clock;

  io_bridge #(.TIMEOUT(TO), .ADDR_W(10)) dut (
    .clock(clock), .rst_n(rst_n), .io_read(io_read), .io_write(io_write),
    .mem_read(mem_read), .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata),
    .rdata(rdata), .stall(stall), .io_req(io_req), .io_we(io_we), .io_cs(io_cs),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_ack(io_ack), .io_rdata(io_rdata),
    .io_err(io_err)
  );

  int          total = 0, bad = 0;
  logic [31:0] model_rq = '0;
  logic        model_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One IO instruction held until stall drops. k = REQ cycles before the ack
  // cycle (ack lands in REQ cycle k+1); k < 0 means the peripheral never acks.
  task automatic io_access(input logic rd, input logic wr, input logic [9:0] a,
                           input logic [31:0] wd, input int k, input logic [31:0] rdat);
    logic [2:0]  cs_exp;
    logic [31:0] mrd;
    int stalls = 0, reqs = 0, exp_stalls, exp_reqs;
    bit fin = 0;
    case (a[9:2])
      8'h18:   cs_exp = 3'b001;
      8'h1C:   cs_exp = 3'b010;
      8'h20:   cs_exp = 3'b100;
      default: cs_exp = 3'b000;
    endcase
    mrd = $urandom;
    io_read = rd; io_write = wr; addr = a; wdata = wd;
    mem_rdata = mrd; mem_read = 1'($urandom); io_ack = 1'b0;
    for (int c = 0; c < 64 && !fin; c++) begin
      #1;
      if (io_req) begin
        reqs++;
        chk("bus_cs", 32'(io_cs), 32'(cs_exp));
        chk("bus_we", 32'(io_we), 32'(wr));
        chk("bus_addr", 32'(io_addr), 32'(a[1:0]));
        chk("bus_wdata", io_wdata, wd);
        if (k >= 0 && reqs == k + 1) begin io_ack = 1'b1; io_rdata = rdat; end
        else begin io_ack = 1'b0; io_rdata = $urandom; end
      end else begin
        io_ack = 1'($urandom); io_rdata = $urandom;
      end
      if (!stall) fin = 1;
      else begin
        stalls++;
        @(negedge clock);
        wdata = $urandom;
      end
    end
    if (cs_exp == 3'b000) begin
      exp_stalls = 1; exp_reqs = 0; model_rq = '0;
    end else if (k < 0) begin
      exp_stalls = 1 + TO; exp_reqs = TO; model_rq = 32'hDEAD_BEEF; model_err = 1'b1;
    end else begin
      exp_stalls = k + 2; exp_reqs = k + 1;
      if (!wr) model_rq = rdat;
    end
    chk("stall_end", 32'(stall), 32'd0);
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    chk("req_cycles", 32'(reqs), 32'(exp_reqs));
    chk("req_done", 32'(io_req), 32'd0);
    chk("rdata", rdata, rd ? model_rq : mrd);
    chk("io_err", 32'(io_err), 32'(model_err));
    @(negedge clock);
    io_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    int sel;
    rst_n = 1'b0; io_read = 1'b1; io_write = 1'b0; mem_read = 1'b0; io_ack = 1'b0;
    addr = '0; wdata = '0; mem_rdata = 32'h5555_AAAA; io_rdata = '0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_req", 32'(io_req), 32'd0);
    chk("rst_we", 32'(io_we), 32'd0);
    chk("rst_cs", 32'(io_cs), 32'd0);
    chk("rst_addr", 32'(io_addr), 32'd0);
    chk("rst_wdata", io_wdata, 32'd0);
    chk("rst_err", 32'(io_err), 32'd0);
    io_read = 1'b0;
    #1 chk("rst_memrd", rdata, 32'h5555_AAAA);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);

    io_access(1'b1, 1'b0, 10'h070, 32'h0, 1, 32'h0000_A5A5);   // SW read
    io_access(1'b0, 1'b1, 10'h060, 32'hFF, 0, 32'h0);          // LED write
    io_access(1'b1, 1'b0, 10'h090, 32'h0, 0, 32'h0);           // unmapped read
`ifdef IO_TIMEOUT_EN
    io_access(1'b1, 1'b0, 10'h080, 32'h0, -1, 32'h0);          // no ack -> abort
`endif

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        do w = 8'($urandom); while (w == 8'h18 || w == 8'h1C || w == 8'h20);
      end else begin
        case ($urandom_range(0, 2))
          0: w = 8'h18;
          1: w = 8'h1C;
          default: w = 8'h20;
        endcase
      end
      io_access(sel != 1, sel != 0, {w, 2'($urandom)}, $urandom,
                $urandom_range(0, 3), $urandom);
    end

    // Reset mid-request, then a late ack must be ignored.
    io_read = 1'b1; io_write = 1'b0; addr = 10'h070; io_ack = 1'b0;
    for (int c = 0; c < 8 && !io_req; c++) begin
      @(negedge clock); #1;
    end
    chk("pre_rst_req", 32'(io_req), 32'd1);
    @(negedge clock);
    rst_n = 1'b0; io_read = 1'b0;
    @(negedge clock); #1;
    model_rq = '0; model_err = 1'b0;
    chk("rst_mid_req", 32'(io_req), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_err", 32'(io_err), 32'd0);
    rst_n = 1'b1; io_ack = 1'b1; io_rdata = $urandom;
    repeat (2) @(negedge clock);
    #1;
    chk("late_ack_req", 32'(io_req), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    io_ack = 1'b0; mem_read = 1'b1; mem_rdata = 32'h0000_1234;
    #1;
    chk("mem_rdata", rdata, 32'h0000_1234);
    chk("mem_stall", 32'(stall), 32'd0);
    mem_read = 1'b0;
    @(negedge clock);
    io_access(1'b1, 1'b1, 10'h080, 32'hCAFE_0001, 2, 32'h0);   // both high -> write

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
